// File: rtl/fsm_pkg.sv
// Shared types and default constants for the door-lock sequence detector.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake; the keypad word is sampled every clock).
package fsm_pkg;

  // Detector states: S1..S3 mean "CODE0..CODE2 accepted so far".
  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    LOCK = 3'd4
  } state_t;

  // Default unlock sequence and the "no key pressed" word.
  localparam logic [15:0] DEF_CODE0     = 16'hDF6F;
  localparam logic [15:0] DEF_CODE1     = 16'hB6DF;
  localparam logic [15:0] DEF_CODE2     = 16'hD6FF;
  localparam logic [15:0] DEF_CODE3     = 16'hF6DB;
  localparam logic [15:0] DEF_IDLE_WORD = 16'h0000;

  // Default lockout policy.
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 8;

endpackage

// File: rtl/fsm_lock_timer.sv
// Lockout down-counter: loads LOCK_CYCLES on lockout entry, counts down while running.
// Latency: done is combinational from the count register, high in the final lockout cycle.
// Backpressure: none; load has priority over run.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset, clears the count
//   load  - lockout entry: count <= LOCK_CYCLES
//   run   - lockout in progress: count decrements toward 0
//   done  - the count reaches 0 at the next edge (lockout ends there)
module fsm_lock_timer #(
  parameter int LOCK_CYCLES = fsm_pkg::DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic done
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(LOCK_CYCLES);
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // The entry edge already counts as the first lockout cycle, so the last
  // cycle is the one where the count still reads 1 and hits 0 on exit.
  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/fsm.sv
// Door-lock sequence detector: four-word code match -> unlock pulse; repeated failures -> timed lockout.
// Latency: z/try are registered, one cycle after the deciding word is sampled; reset_try rises with the final try.
// Backpressure: none; x is sampled every edge and ignored while locked out.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   x[15:0]    - keypad/code word
//   z          - one-cycle unlock pulse
//   try        - one-cycle failed-attempt pulse
//   reset_try  - high for the whole lockout
module fsm
  import fsm_pkg::*;
#(
  parameter logic [15:0] CODE0       = DEF_CODE0,
  parameter logic [15:0] CODE1       = DEF_CODE1,
  parameter logic [15:0] CODE2       = DEF_CODE2,
  parameter logic [15:0] CODE3       = DEF_CODE3,
  parameter logic [15:0] IDLE_WORD   = DEF_IDLE_WORD,
  parameter int          MAX_TRIES   = DEF_MAX_TRIES,
  parameter int          LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  output logic        z,
  output logic        try,
  output logic        reset_try
);

  localparam int            FW       = $clog2(MAX_TRIES + 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_TRIES);

  state_t        state_q, state_d, state_adv;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic [15:0]   code_exp, code_prev;
  logic          z_d, try_d;
  logic          timer_load, timer_done;

  fsm_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .run  (state_q == LOCK),
    .done (timer_done)
  );

  // Per-state expected word, the word that may legitimately still be held
  // from the previous step, and the state reached on a match.
  always_comb begin
    code_exp  = CODE1;
    code_prev = CODE0;
    state_adv = S2;
    case (state_q)
      S2: begin
        code_exp  = CODE2;
        code_prev = CODE1;
        state_adv = S3;
      end
      S3: begin
        code_exp  = CODE3;
        code_prev = CODE2;
        state_adv = S0;
      end
      default: ;
    endcase
  end

  // Saturating increment; the counter never wraps back to a low value.
  assign fail_inc = (fail_q >= FAIL_MAX) ? fail_q : fail_q + FW'(1);

  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    z_d        = 1'b0;
    try_d      = 1'b0;
    timer_load = 1'b0;

    case (state_q)
      S0: begin
        // Nothing entered yet, so a stray word is not an attempt.
        if (x == CODE0) begin
          state_d = S1;
        end
      end

      S1, S2, S3: begin
        if (x == code_exp) begin
          state_d = state_adv;
          if (state_q == S3) begin
            z_d    = 1'b1;
            fail_d = '0;
          end
        end else if ((x == IDLE_WORD) || (x == code_prev)) begin
          // Key still held or released between presses: wait.
          state_d = state_q;
        end else begin
          try_d  = 1'b1;
          fail_d = fail_inc;
          if (fail_inc >= FAIL_MAX) begin
            state_d    = LOCK;
            timer_load = 1'b1;
          end else begin
            state_d = S0;
          end
        end
      end

      LOCK: begin
        if (timer_done) begin
          state_d = S0;
          fail_d  = '0;
        end
      end

      default: begin
        state_d = S0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S0;
      fail_q    <= '0;
      z         <= 1'b0;
      try       <= 1'b0;
      reset_try <= 1'b0;
    end else begin
      state_q   <= state_d;
      fail_q    <= fail_d;
      z         <= z_d;
      try       <= try_d;
      // Registered from the next state so it rises with the final try pulse
      // and drops on the same edge the FSM returns to S0.
      reset_try <= (state_d == LOCK);
    end
  end

endmodule

// File: tb/tb_fsm.sv
module tb_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x   = 16'hFFFF;
  logic        z;
  logic        try_pulse;
  logic        reset_try;

  int n_checks = 0;
  int n_fail   = 0;
  int z_cnt    = 0;
  int try_cnt  = 0;
  int lock_cnt = 0;

  localparam logic [15:0] C0 = 16'hDF6F;
  localparam logic [15:0] C1 = 16'hB6DF;
  localparam logic [15:0] C2 = 16'hD6FF;
  localparam logic [15:0] C3 = 16'hF6DB;

  fsm dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .z         (z),
    .try       (try_pulse),
    .reset_try (reset_try)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cnt();
    z_cnt    = 0;
    try_cnt  = 0;
    lock_cnt = 0;
  endtask

  // Drive one word for one edge, then sample the outputs 1 time unit later.
  task automatic apply(input logic [15:0] w);
    x = w;
    @(posedge clk);
    #1;
    z_cnt    += int'(z);
    try_cnt  += int'(try_pulse);
    lock_cnt += int'(reset_try);
  endtask

  task automatic unlock_seq();
    apply(C0);
    apply(C1);
    apply(C2);
    apply(C3);
  endtask

  task automatic fail_attempt();
    apply(C0);
    apply(16'h5555);
  endtask

  // Release reset away from the edge; the next edge is the first sample.
  task automatic release_rst();
    x = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle and check the outputs drop without a clock edge.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_z"}, {31'd0, z}, 32'd0);
    check({tag, "_try"}, {31'd0, try_pulse}, 32'd0);
    check({tag, "_reset_try"}, {31'd0, reset_try}, 32'd0);
    @(posedge clk);
    release_rst();
  endtask

  initial begin
    // Reset with FFFF on the bus.
    #12;
    check("rst_z", {31'd0, z}, 32'd0);
    check("rst_try", {31'd0, try_pulse}, 32'd0);
    check("rst_reset_try", {31'd0, reset_try}, 32'd0);
    x = 16'hFFFF;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply(16'hFFFF);
    check("ffff_not_a_failure", {31'd0, try_pulse}, 32'd0);

    // Held and released keys stretch the sequence without penalty.
    clear_cnt();
    apply(C0); apply(C0); apply(C0); apply(C0);
    apply(C1); apply(C2); apply(16'h0000);
    check("z_before_last_word", {31'd0, z}, 32'd0);
    apply(C3);
    check("unlock_pulse", {31'd0, z}, 32'd1);
    apply(16'h0000);
    check("unlock_one_cycle", {31'd0, z}, 32'd0);
    check("held_seq_z_count", z_cnt, 32'd1);
    check("held_seq_try_count", try_cnt, 32'd0);

    // Wrong third word: one failure, back to S0, then a clean unlock.
    clear_cnt();
    apply(C0); apply(C1); apply(16'hAAAA);
    check("fail_pulse", {31'd0, try_pulse}, 32'd1);
    check("fail_no_lock", {31'd0, reset_try}, 32'd0);
    apply(C0);
    check("fail_one_cycle", {31'd0, try_pulse}, 32'd0);
    apply(C1); apply(C2); apply(C3);
    check("unlock_after_fail", {31'd0, z}, 32'd1);

    // Three failures: lockout for 8 cycles, input ignored meanwhile.
    clear_cnt();
    fail_attempt(); fail_attempt(); fail_attempt();
    check("three_try_pulses", try_cnt, 32'd3);
    check("lock_rises_with_try", {31'd0, reset_try}, 32'd1);
    clear_cnt();
    unlock_seq();
    apply(16'h0000); apply(16'h0000); apply(16'h0000);
    check("lock_last_cycle", {31'd0, reset_try}, 32'd1);
    check("lock_high_cycles", lock_cnt, 32'd7);
    check("no_z_in_lock", z_cnt, 32'd0);
    check("no_try_in_lock", try_cnt, 32'd0);
    apply(16'h0000);
    check("lock_falls", {31'd0, reset_try}, 32'd0);
    unlock_seq();
    check("unlock_after_lock", {31'd0, z}, 32'd1);

    // Reset during lockout clears outputs at once and the fail counter.
    fail_attempt(); fail_attempt(); fail_attempt();
    check("relock", {31'd0, reset_try}, 32'd1);
    mid_reset("rst_in_lock");
    clear_cnt();
    fail_attempt(); fail_attempt();
    check("counter_cleared_by_rst_lock", lock_cnt, 32'd0);

    // Reset in S2 (two failures pending): partial sequence is forgotten.
    apply(C0); apply(C1);
    mid_reset("rst_in_s2");
    clear_cnt();
    apply(C2); apply(C3);
    check("no_partial_unlock", z_cnt, 32'd0);
    check("no_fail_from_s0", try_cnt, 32'd0);
    fail_attempt();
    check("try_after_rst", {31'd0, try_pulse}, 32'd1);
    check("counter_cleared_by_rst_s2", {31'd0, reset_try}, 32'd0);
    unlock_seq();
    check("full_seq_after_rst", {31'd0, z}, 32'd1);

    // Unlock between failures clears the counter: no lockout.
    clear_cnt();
    fail_attempt(); fail_attempt();
    unlock_seq();
    fail_attempt(); fail_attempt();
    check("unlock_clears_count_lock", lock_cnt, 32'd0);
    check("unlock_clears_count_try", try_cnt, 32'd4);
    check("unlock_clears_count_z", z_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
